// File: rtl/sdrstick_rx_mux_pkg.sv
// Shared types and word-format constants for the receiver-to-FIFO sequencer.
package sdrstick_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_I,
    WR_Q
  } state_t;

  localparam int unsigned TAG_BIT = 31;
  localparam int unsigned CH_LSB  = 24;
  localparam int unsigned CH_W    = 4;
  localparam int unsigned MAX_RX  = 16;

  // Tagged FIFO word: I/Q tag on top, channel in 27:24, sample zero-extended below.
  function automatic logic [31:0] make_word(input logic q_tag, input logic [CH_W-1:0] ch,
                                            input logic [23:0] sample);
    logic [31:0] w;
    w                  = '0;
    w[TAG_BIT]         = q_tag;
    w[CH_LSB +: CH_W]  = ch;
    w[23:0]            = sample;
    return w;
  endfunction

endpackage

// File: rtl/sdrstick_rx_mux_if.sv
// Receiver-side strobes/samples plus FIFO write port and status of the sequencer.
interface sdrstick_rx_mux_if #(
  parameter int unsigned NUM_RX   = 4,
  parameter int unsigned SAMPLE_W = 24
);
  logic [NUM_RX-1:0]          rx_strobe;
  logic [NUM_RX*SAMPLE_W-1:0] rx_i;
  logic [NUM_RX*SAMPLE_W-1:0] rx_q;
  logic [NUM_RX-1:0]          ch_enable;
  logic [NUM_RX-1:0]          ovr_clear;
  logic                       fifo_full;
  logic [31:0]                fifo_writedata;
  logic                       fifo_write;
  logic [NUM_RX-1:0]          ovr_flag;
  logic [15:0]                drop_count;
  logic                       busy;

  modport master (
    output rx_strobe, rx_i, rx_q, ch_enable, ovr_clear, fifo_full,
    input  fifo_writedata, fifo_write, ovr_flag, drop_count, busy
  );

  modport slave (
    input  rx_strobe, rx_i, rx_q, ch_enable, ovr_clear, fifo_full,
    output fifo_writedata, fifo_write, ovr_flag, drop_count, busy
  );
endinterface

// File: rtl/sdrstick_rr_pick.sv
// Combinational round-robin search: first set request strictly after ptr, with wrap.
module sdrstick_rr_pick
  import sdrstick_rx_pkg::*;
#(
  parameter int unsigned NUM_RX = 4
) (
  input  logic [NUM_RX-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_valid
);

  int unsigned       idx;
  logic [NUM_RX-1:0] req_sh;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    req_sh    = '0;
    for (int unsigned off = 1; off <= NUM_RX; off++) begin
      idx    = (32'(ptr) + off) % NUM_RX;
      req_sh = req >> idx;
      if (!gnt_valid && req_sh[0]) begin
        gnt_idx   = CH_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdrstick_rx_mux.sv
// Captures per-channel I/Q strobes and drains them round-robin as tagged I-then-Q
// word pairs onto the FIFO write port, with backpressure and overrun accounting.
module sdrstick_rx_mux
  import sdrstick_rx_pkg::*;
#(
  parameter int unsigned NUM_RX   = 4,
  parameter int unsigned SAMPLE_W = 24
) (
  input logic              clk,
  input logic              reset_n,
  sdrstick_rx_mux_if.slave bus
);

  state_t              state;
  logic [NUM_RX-1:0]   pending;
  logic [SAMPLE_W-1:0] hold_i [NUM_RX];
  logic [SAMPLE_W-1:0] hold_q [NUM_RX];
  logic [SAMPLE_W-1:0] stage_i, stage_q, sel_i, sel_q;
  logic [CH_W-1:0]     rr_ptr, grant_ch, pick_idx;
  logic                pick_valid, grant_now;
  logic [NUM_RX-1:0]   req, grant_vec, drop_vec;
  logic [4:0]          drop_n;
  logic [16:0]         drop_sum;
  logic [31:0]         wdata;
  logic                wr;
  logic [NUM_RX-1:0]   ovr;
  logic [15:0]         drops;

  assign req = pending & bus.ch_enable;

  sdrstick_rr_pick #(.NUM_RX(NUM_RX)) u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  always_comb begin
    grant_now = (state == IDLE) && pick_valid;
    grant_vec = '0;
    drop_vec  = '0;
    drop_n    = '0;
    sel_i     = '0;
    sel_q     = '0;
    for (int unsigned k = 0; k < NUM_RX; k++) begin
      if (CH_W'(k) == pick_idx) begin
        grant_vec[k] = grant_now;
        sel_i        = hold_i[k];
        sel_q        = hold_q[k];
      end
      drop_vec[k] = bus.ch_enable[k] & bus.rx_strobe[k] & pending[k] & ~grant_vec[k];
      drop_n      = drop_n + 5'(drop_vec[k]);
    end
    drop_sum = 17'(drops) + 17'(drop_n);
  end

  // A strobe landing on its own grant edge refills the holding register while staging takes the old sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      ovr     <= '0;
      drops   <= '0;
      for (int unsigned k = 0; k < NUM_RX; k++) begin
        hold_i[k] <= '0;
        hold_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_RX; k++) begin
        if (!bus.ch_enable[k]) begin
          pending[k] <= 1'b0;
        end else if (bus.rx_strobe[k] && (!pending[k] || grant_vec[k])) begin
          hold_i[k]  <= bus.rx_i[k*SAMPLE_W +: SAMPLE_W];
          hold_q[k]  <= bus.rx_q[k*SAMPLE_W +: SAMPLE_W];
          pending[k] <= 1'b1;
        end else if (grant_vec[k]) begin
          pending[k] <= 1'b0;
        end
      end
      ovr   <= (ovr & ~bus.ovr_clear) | drop_vec;
      drops <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= CH_W'(NUM_RX - 1);
      grant_ch <= '0;
      stage_i  <= '0;
      stage_q  <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr <= 1'b0;
          if (grant_now) begin
            stage_i  <= sel_i;
            stage_q  <= sel_q;
            grant_ch <= pick_idx;
            rr_ptr   <= pick_idx;
            state    <= WR_I;
          end
        end
        WR_I: begin
          if (!bus.fifo_full) begin
            wdata <= make_word(1'b0, grant_ch, 24'(stage_i));
            wr    <= 1'b1;
            state <= WR_Q;
          end else begin
            wr <= 1'b0;
          end
        end
        WR_Q: begin
          if (!bus.fifo_full) begin
            wdata <= make_word(1'b1, grant_ch, 24'(stage_q));
            wr    <= 1'b1;
            state <= IDLE;
          end else begin
            wr <= 1'b0;
          end
        end
        default: begin
          wr    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_writedata = wdata;
  assign bus.fifo_write     = wr;
  assign bus.ovr_flag       = ovr;
  assign bus.drop_count     = drops;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_sdrstick_rx_mux.sv
// Scoreboarded bench for sdrstick_rx_mux: directed scenarios then randomized traffic.
module tb_sdrstick_rx_mux;
  localparam int N  = 4;
  localparam int SW = 24;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sdrstick_rx_mux_if #(.NUM_RX(N), .SAMPLE_W(SW)) bus ();
  sdrstick_rx_mux #(.NUM_RX(N), .SAMPLE_W(SW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: slot per channel, one pair in service, words emitted as plain arithmetic.
  bit   [N-1:0]  m_pend;
  logic [23:0]   m_hi [N];
  logic [23:0]   m_hq [N];
  int            m_left, m_ch, m_last, m_drops;
  logic [23:0]   m_ci, m_cq;
  bit            m_wr;
  logic [31:0]   m_word;
  logic [N-1:0]  m_ovr;
  logic [31:0]   exp_q [$];

  function automatic logic [31:0] word_of(input int tag, input int ch, input logic [23:0] s);
    return (32'(tag) << 31) | (32'(ch) << 24) | 32'(s);
  endfunction

  task automatic model_reset();
    m_pend = '0;
    for (int k = 0; k < N; k++) begin
      m_hi[k] = '0;
      m_hq[k] = '0;
    end
    m_left = 0; m_ch = 0; m_last = N - 1; m_drops = 0;
    m_ci = '0; m_cq = '0; m_wr = 1'b0; m_word = '0; m_ovr = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int grant;
    int nd;
    logic [N-1:0] st, en, setv;
    grant = -1; nd = 0; setv = '0;
    st = bus.rx_strobe;
    en = bus.ch_enable;
    m_wr = 1'b0;
    if (m_left == 0) begin
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_last + off) % N;
        if (grant < 0 && m_pend[c] && en[c]) grant = c;
      end
    end else if (!bus.fifo_full) begin
      m_word = (m_left == 2) ? word_of(0, m_ch, m_ci) : word_of(1, m_ch, m_cq);
      exp_q.push_back(m_word);
      m_wr = 1'b1;
      m_left--;
    end
    if (grant >= 0) begin
      m_ch = grant; m_ci = m_hi[grant]; m_cq = m_hq[grant]; m_left = 2; m_last = grant;
    end
    for (int k = 0; k < N; k++) begin
      if (!en[k]) m_pend[k] = 1'b0;
      else if (st[k]) begin
        if (m_pend[k] && grant != k) begin
          setv[k] = 1'b1;
          nd++;
        end else begin
          m_hi[k]   = bus.rx_i[k*SW +: SW];
          m_hq[k]   = bus.rx_q[k*SW +: SW];
          m_pend[k] = 1'b1;
        end
      end else if (grant == k) m_pend[k] = 1'b0;
    end
    m_ovr   = (m_ovr & ~bus.ovr_clear) | setv;
    m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_edge();
    end
  end

  // Monitor: compares every cycle on the falling edge, pops the scoreboard on each write.
  initial begin
    forever begin
      @(negedge clk);
      check("fifo_write", 32'(bus.fifo_write), 32'(m_wr));
      if (bus.fifo_write && exp_q.size() > 0) check("word", bus.fifo_writedata, exp_q.pop_front());
      else if (!bus.fifo_write) check("data_hold", bus.fifo_writedata, m_word);
      check("ovr_flag", 32'(bus.ovr_flag), 32'(m_ovr));
      check("drop_count", 32'(bus.drop_count), 32'(m_drops));
      check("busy", 32'(bus.busy), 32'(m_left != 0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int ch, input logic [23:0] i, input logic [23:0] q);
    bus.rx_strobe[ch]       = 1'b1;
    bus.rx_i[ch*SW +: SW]   = i;
    bus.rx_q[ch*SW +: SW]   = q;
  endtask

  logic [31:0] cw [8];
  int          got;

  task automatic collect(input int n);
    got = 0;
    for (int j = 0; j < 8; j++) cw[j] = '1;
    for (int c = 0; c < 40 && got < n; c++) begin
      step();
      if (bus.fifo_write) begin
        cw[got] = bus.fifo_writedata;
        got++;
      end
    end
  endtask

  int nwr;

  initial begin
    reset_n = 1'b0;
    bus.rx_strobe = '0; bus.rx_i = '0; bus.rx_q = '0;
    bus.ch_enable = '1; bus.ovr_clear = '0; bus.fifo_full = 1'b0;
    repeat (3) step();
    check("rst_write", 32'(bus.fifo_write), 0);
    check("rst_data", bus.fifo_writedata, 0);
    check("rst_ovr", 32'(bus.ovr_flag), 0);
    check("rst_drop", 32'(bus.drop_count), 0);
    check("rst_busy", 32'(bus.busy), 0);
    reset_n = 1'b1;
    step();

    // Single channel latency and word format
    strobe(2, 24'h123456, 24'hABCDEF);
    step();
    bus.rx_strobe = '0;
    step();
    check("lat_e1_write", 32'(bus.fifo_write), 0);
    step();
    check("lat_e2_write", 32'(bus.fifo_write), 1);
    check("lat_i_word", bus.fifo_writedata, 32'h02123456);
    step();
    check("lat_e3_write", 32'(bus.fifo_write), 1);
    check("lat_q_word", bus.fifo_writedata, 32'h82ABCDEF);

    // Simultaneous bursts after reset
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) strobe(k, 24'($urandom), 24'($urandom));
      step();
      bus.rx_strobe = '0;
      collect(8);
      for (int j = 0; j < 8; j++)
        check("burst_hdr", 32'({cw[j][31], cw[j][27:24]}), 32'(((j % 2) << 4) | (j / 2)));
    end

    // Backpressure stall in WR_I
    strobe(1, 24'h5A5A5A, 24'hC3C3C3);
    step();
    bus.rx_strobe = '0;
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("stall_write", 32'(bus.fifo_write), 0);
    end
    bus.fifo_full = 1'b0;
    step();
    check("stall_i_word", bus.fifo_writedata, 32'h015A5A5A);
    check("stall_i_write", 32'(bus.fifo_write), 1);
    step();
    check("stall_q_word", bus.fifo_writedata, 32'h81C3C3C3);

    // Overrun while stalled
    bus.fifo_full = 1'b1;
    strobe(1, 24'h0000A1, 24'h0000A2);
    step(); bus.rx_strobe = '0;
    step();
    strobe(1, 24'h0000B1, 24'h0000B2);
    step(); bus.rx_strobe = '0;
    step();
    strobe(1, 24'h0000C1, 24'h0000C2);
    step(); bus.rx_strobe = '0;
    check("ovr_set", 32'(bus.ovr_flag), 32'h2);
    check("ovr_drop", 32'(bus.drop_count), 1);
    bus.fifo_full = 1'b0;
    collect(4);
    check("ovr_first", cw[0], 32'h010000A1);
    check("ovr_second", cw[2], 32'h010000B1);
    bus.ovr_clear = 4'b0010;
    step();
    bus.ovr_clear = '0;
    check("ovr_clear", 32'(bus.ovr_flag), 0);

    // Strobe on the grant edge
    strobe(0, 24'h111111, 24'h222222);
    step();
    strobe(0, 24'h333333, 24'h444444);
    step();
    bus.rx_strobe = '0;
    collect(4);
    check("ge_old_i", cw[0], 32'h00111111);
    check("ge_old_q", cw[1], 32'h80222222);
    check("ge_new_i", cw[2], 32'h00333333);
    check("ge_ovr", 32'(bus.ovr_flag), 0);

    // Disabled channel ignores strobes
    bus.ch_enable = 4'b1101;
    strobe(1, 24'h777777, 24'h888888);
    step();
    bus.rx_strobe = '0;
    nwr = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.fifo_write) nwr++;
    end
    check("dis_writes", 32'(nwr), 0);
    check("dis_drop", 32'(bus.drop_count), 1);
    bus.ch_enable = '1;

    // Async reset mid-pair
    strobe(3, 24'h0F0F0F, 24'hF0F0F0);
    step(); bus.rx_strobe = '0;
    strobe(2, 24'h000001, 24'h000002);
    step(); bus.rx_strobe = '0;
    strobe(2, 24'h000003, 24'h000004);
    step(); bus.rx_strobe = '0;
    check("mid_write", 32'(bus.fifo_write), 1);
    check("mid_ovr", 32'(bus.ovr_flag), 32'h4);
    check("mid_drop", 32'(bus.drop_count), 2);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_write", 32'(bus.fifo_write), 0);
    check("arst_ovr", 32'(bus.ovr_flag), 0);
    check("arst_drop", 32'(bus.drop_count), 0);
    check("arst_busy", 32'(bus.busy), 0);
    repeat (2) step();
    reset_n = 1'b1;
    nwr = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.fifo_write) nwr++;
    end
    check("arst_no_partial", 32'(nwr), 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.rx_strobe = '0;
      bus.ovr_clear = '0;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 5) == 0) strobe(k, 24'($urandom), 24'($urandom));
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) bus.ch_enable = N'($urandom);
      else if ($urandom_range(0, 9) == 0) bus.ch_enable = '1;
      if ($urandom_range(0, 19) == 0) bus.ovr_clear = N'($urandom);
      step();
    end
    bus.rx_strobe = '0; bus.ovr_clear = '0; bus.fifo_full = 1'b0; bus.ch_enable = '1;
    for (int c = 0; c < 100 && (m_left != 0 || m_pend != '0); c++) step();
    repeat (2) step();
    check("drain_busy", 32'(bus.busy), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
